fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares one width-converting FIFO write port among NUM_REQ producers. Each producer offers DATA_WIDTH-bit words on a valid/ready handshake. The arbiter grants the port round-robin in bursts of up to BURST_LEN words and drives the FIFO's wr/w_data, stalling on full. It sits directly in front of the fifo block (DATA_WIDTH in, DATA_WIDTH/2 out).

## Interface
- DATA_WIDTH, 8, FIFO write word width
- NUM_REQ, 4, number of requesters (2..8)
- BURST_LEN, 4, max words per grant (1..16)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- fifo_full  in  1  FIFO full flag
- fifo_wr  out  1  FIFO write strobe
- fifo_w_data  out  DATA_WIDTH  FIFO write data
- grant  out  NUM_REQ  registered one-hot owner of the port; zero when idle
- busy  out  1  high while in BURST

## Operation
- Reset values: grant=0, busy=0, req_ready=0, fifo_wr=0, fifo_w_data=0, rr_ptr=0, beat_cnt=0, state=IDLE.
- Transfer: occurs in a cycle where grant[g]=1, req_valid[g]=1 and fifo_full=0.
- In a transfer cycle: fifo_wr=1, req_ready[g]=1, fifo_w_data=req_data slice g.
- Outputs in all other cycles: fifo_wr=0, req_ready=0.
- fifo_w_data is muxed from the granted slice while in BURST and is 0 in IDLE.
- fifo_wr and req_ready are combinational from the registered grant, req_valid and fifo_full.
- State IDLE:
  - If any req_valid bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register grant to that one-hot, clear beat_cnt, go to BURST.
  - Otherwise stay in IDLE.
- State BURST:
  - Each transfer increments beat_cnt.
  - Release when a transfer makes beat_cnt reach BURST_LEN, or when req_valid[g]=0 at a clock edge.
  - Release action: grant←0, rr_ptr←(g+1) mod NUM_REQ, go to IDLE.
- fifo_full=1 stalls the burst: no transfer, beat_cnt holds, grant holds. Full never releases the grant.
- A requester that drops valid during a stall loses the grant. Its remaining words rearbitrate later.
- req_valid of non-granted requesters is ignored during BURST. Their requests are evaluated at the next IDLE.
- Reset asserted mid-burst: all state clears immediately. Words already written stay in the FIFO. The untransferred remainder is not written.

## Timing
- Arbitration latency: req_valid rises before edge n in IDLE → grant at edge n → first fifo_wr in cycle n (after edge n).
- One IDLE bubble cycle between consecutive bursts.
- Peak throughput: BURST_LEN words per BURST_LEN+1 cycles.
- Worst-case wait for requester i, with no full stalls: (NUM_REQ-1)·(BURST_LEN+1) cycles.
- BURST_LEN=1: every word costs two cycles and the port alternates among all active requesters.

## Configuration
- Macro FIFO_WR_ARBITER_STATS_EN.
- Defined:
  - Adds output word_count, NUM_REQ*16 bits: one 16-bit counter per requester at [i*16 +: 16].
  - Each counter increments on every transfer for that requester and wraps 0xFFFF→0.
  - All counters reset to 0.
- Undefined: the port and counters are absent. Core behaviour is identical.

## Test plan
- Reset release, no requests: for 10 cycles grant=0, fifo_wr=0, busy=0, req_ready=0.
- Requester 1 only, valid held, data 0x01,0x03,0x80,0x30,0x00, fifo_full=0:
  - 4 writes on consecutive cycles, then 1 IDLE cycle, then the 5th write.
  - FIFO sees the data in order.
- All four valid continuously, fifo_full=0:
  - Grant order 0,1,2,3,0.
  - Each burst is exactly 4 fifo_wr pulses followed by one gap cycle.
- Requester 2 granted, fifo_full forced high for 3 cycles after its 2nd word:
  - No fifo_wr and req_ready=0 during the stall.
  - Grant held; burst resumes and totals 4 words.
- Requester 0 drops valid after 2 words while requester 3 is valid: grant moves to requester 3 after one IDLE cycle; rr_ptr=1.
- reset_n pulsed low mid-burst after 1 word:
  - Outputs zero asynchronously.
  - After release, arbitration restarts at requester 0.
  - With STATS_EN, word_count clears to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Define FIFO_WR_ARBITER_STATS_EN to add per-requester 16-bit transfer counters (word_count).
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
`ifdef FIFO_WR_ARBITER_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         word_count
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]      gidx_q, gidx_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

   logic                  sel_found;
   logic [IDX_W-1:0]      sel_idx;
   logic                  owner_valid;
   logic                  xfer;
   logic                  last_beat;
   logic [IDX_W-1:0]      next_ptr;
   logic [DATA_WIDTH-1:0] slice [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // grant_q is zero in IDLE, so owner_valid alone also qualifies the state
   assign owner_valid = |(grant_q & req_valid);
   assign xfer        = (state_q == BURST) && owner_valid && !fifo_full;
   assign last_beat   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
   assign next_ptr    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

   assign req_ready   = xfer ? grant_q : '0;
   assign fifo_wr     = xfer;
   assign fifo_w_data = (state_q == BURST) ? slice[gidx_q] : '0;
   assign grant       = grant_q;
   assign busy        = (state_q == BURST);

   // Scan from the highest offset down so the lowest offset from rr_ptr wins
   always_comb begin
      logic [IDX_W-1:0] idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            sel_found = 1'b1;
            sel_idx   = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d    = BURST;
               grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
               gidx_d     = sel_idx;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (!owner_valid || (xfer && last_beat)) begin
               state_d    = IDLE;
               grant_d    = '0;
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARBITER_STATS_EN
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         logic [15:0] cnt_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else if (req_ready[gi]) begin
               cnt_q <= cnt_q + 16'd1;
            end
         end
         assign word_count[gi*16 +: 16] = cnt_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: reference model predicts writes, monitor pops and compares.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int BL = 4;
   localparam int SD = 64;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            fifo_full;
   logic            fifo_wr;
   logic [DW-1:0]   fifo_w_data;
   logic [NR-1:0]   grant;
   logic            busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
   logic [NR*16-1:0] word_count;
`endif

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
      .fifo_w_data(fifo_w_data), .grant(grant), .busy(busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
      , .word_count(word_count)
`endif
   );

   always #10 clk = ~clk;

   typedef struct { int req; logic [DW-1:0] data; } wr_t;
   wr_t exp_q[$];
   int            log_req[$];
   int            log_cyc[$];
   int            log_dat[$];

   // per-producer word sources
   logic [DW-1:0] src_mem [NR][SD];
   int            src_rd [NR];
   int            src_wr [NR];

   int            m_owner, m_beats, m_ptr;
   logic [15:0]   m_cnt [NR];
   int            cyc = 0;
   logic [NR-1:0] vmask = '1;
   bit            rnd_mode = 0;
   int            stall_left = 0;
   int            n_chk = 0;
   int            n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic int lreq(int k); return (k < log_req.size()) ? log_req[k] : -1; endfunction
   function automatic int lcyc(int k); return (k < log_cyc.size()) ? log_cyc[k] : -100; endfunction
   function automatic int ldat(int k); return (k < log_dat.size()) ? log_dat[k] : -1; endfunction

   task automatic push_src(int i, logic [DW-1:0] d);
      src_mem[i][src_wr[i] % SD] = d;
      src_wr[i]++;
   endtask

   task automatic clear_log();
      log_req.delete(); log_cyc.delete(); log_dat.delete();
   endtask

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_ptr = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = '0;
      exp_q.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (src_wr[i] != src_rd[i]) && vmask[i];
         req_data[i*DW +: DW] = (src_wr[i] != src_rd[i]) ? src_mem[i][src_rd[i] % SD] : DW'($urandom);
      end
      fifo_full = rnd_mode ? ($urandom_range(0, 4) == 0) : 1'b0;
      if (stall_left > 0 && m_owner == 2 && m_beats == 2) begin
         fifo_full = 1'b1;
         stall_left--;
      end
   endtask

   // Reference: owner of the port, words granted so far, next scan start
   task automatic model_cycle();
      logic [NR-1:0] eg;
      wr_t e;
      bit found;
      int c;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("grant", grant, eg);
      chk("busy", busy, m_owner >= 0);
      if (m_owner < 0) chk("idle_data", fifo_w_data, 0);
`ifdef FIFO_WR_ARBITER_STATS_EN
      for (int i = 0; i < NR; i++) chk("word_count", word_count[i*16 +: 16], m_cnt[i]);
`endif
      if (m_owner >= 0) begin
         if (req_valid[m_owner] && !fifo_full) begin
            e.req = m_owner;
            e.data = src_mem[m_owner][src_rd[m_owner] % SD];
            exp_q.push_back(e);
            src_rd[m_owner]++;
            m_cnt[m_owner]++;
            m_beats++;
            if (m_beats == BL) begin
               m_ptr = (m_owner + 1) % NR;
               m_owner = -1;
            end
         end else if (!req_valid[m_owner]) begin
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end else begin
         found = 0;
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (!found && req_valid[c]) begin
               found = 1;
               m_owner = c;
               m_beats = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (!reset_n) reset_n = 1'b1;
      if (rnd_mode) begin
         vmask = NR'($urandom) | NR'($urandom);
         for (int i = 0; i < NR; i++)
            if (src_wr[i] == src_rd[i] && $urandom_range(0, 3) == 0)
               for (int n = 0; n < int'($urandom_range(1, 6)); n++) push_src(i, DW'($urandom));
      end
      drive();
      #1;
      model_cycle();
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_valid = '0; req_data = '0; fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
      model_reset();
      clear_log();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_fifo_wr"}, fifo_wr, 0);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_wdata"}, fifo_w_data, 0);
`ifdef FIFO_WR_ARBITER_STATS_EN
      chk({tag, "_word_count"}, word_count, 0);
`endif
   endtask

   task automatic drained(input string tag);
      #5;
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // Monitor: pops one expectation per observed write
   initial begin
      wr_t e;
      int a;
      logic [NR-1:0] one;
      forever begin
         @(negedge clk);
         #3;
         if (reset_n === 1'b1) begin
            if (fifo_wr === 1'b1) begin
               a = -1;
               for (int i = 0; i < NR; i++) if (req_ready[i]) a = i;
               log_req.push_back(a); log_cyc.push_back(cyc); log_dat.push_back(int'(fifo_w_data));
               if (exp_q.size() == 0) begin
                  chk("unexpected_wr", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  one = '0; one[e.req] = 1'b1;
                  chk("wr_data", fifo_w_data, e.data);
                  chk("wr_ready", req_ready, one);
                  $display("write cyc=%0d req=%0d data=%02h", cyc, a, fifo_w_data);
               end
            end else begin
               chk("noxfer_ready", req_ready, 0);
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] t2 [5];
      t2[0] = 8'h01; t2[1] = 8'h03; t2[2] = 8'h80; t2[3] = 8'h30; t2[4] = 8'h00;

      // Reset, no requests
      do_reset();
      reset_n = 1'b0;
      #1 check_zero("reset");
      @(negedge clk); reset_n = 1'b1;
      repeat (10) step();
      drained("t1");

      // Requester 1 only, five words
      do_reset();
      for (int k = 0; k < 5; k++) push_src(1, t2[k]);
      repeat (12) step();
      drained("t2");
      chk("t2_count", log_req.size(), 5);
      for (int k = 0; k < 5; k++) begin
         chk("t2_req", lreq(k), 1);
         chk("t2_data", ldat(k), t2[k]);
      end
      for (int k = 1; k < 5; k++) chk("t2_gap", lcyc(k) - lcyc(k-1), (k == 4) ? 2 : 1);

      // All four continuously valid
      do_reset();
      for (int i = 0; i < NR; i++) for (int k = 0; k < 8; k++) push_src(i, DW'(i*16 + k));
      repeat (26) step();
      drained("t3");
      for (int k = 0; k < 20; k++) chk("t3_order", lreq(k), (k / BL) % NR);
      for (int k = 1; k < 20; k++) chk("t3_gap", lcyc(k) - lcyc(k-1), (k % BL == 0) ? 2 : 1);

      // Requester 2 stalled by full after its 2nd word
      do_reset();
      for (int k = 0; k < 4; k++) push_src(2, DW'(8'hA0 + k));
      stall_left = 3;
      repeat (12) step();
      drained("t4");
      chk("t4_count", log_req.size(), 4);
      for (int k = 0; k < 4; k++) chk("t4_req", lreq(k), 2);
      chk("t4_stall_gap", lcyc(2) - lcyc(1), 4);
      chk("t4_stall_used", stall_left, 0);

      // Requester 0 drops valid after 2 words, requester 3 waiting
      do_reset();
      push_src(0, 8'h11); push_src(0, 8'h12);
      for (int k = 0; k < 4; k++) push_src(3, DW'(8'h30 + k));
      repeat (5) step();
      chk("t5_rr_ptr", dut.rr_ptr_q, 1);
      repeat (7) step();
      drained("t5");
      chk("t5_count", log_req.size(), 6);
      for (int k = 0; k < 6; k++) chk("t5_req", lreq(k), (k < 2) ? 0 : 3);
      chk("t5_gap", lcyc(2) - lcyc(1), 3);

      // Reset pulse mid-burst, one word into requester 2's second burst
      do_reset();
      for (int k = 0; k < 6; k++) push_src(2, DW'(8'hC0 + k));
      for (int n = 0; n < 20; n++) begin
         step();
         #5;
         if (log_req.size() >= 5) break;
      end
      chk("t6_prewrites", log_req.size(), 5);
      reset_n = 1'b0;
      #1 check_zero("t6_async");
      model_reset();
      clear_log();
      for (int k = 0; k < 4; k++) begin push_src(0, DW'(8'h50 + k)); push_src(3, DW'(8'h70 + k)); end
      repeat (10) step();
      drained("t6");
      chk("t6_first_req", lreq(0), 0);
      chk("t6_first_data", ldat(0), 8'h50);

      // Randomized traffic with random valid drops and full stalls
      do_reset();
      rnd_mode = 1;
      repeat (800) step();
      rnd_mode = 0;
      drained("rand");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule
